// File: rtl/fc_1.sv
// First fully-connected LeNet layer: 16 pooled words x 25 lanes per neuron, bias, ReLU,
// and a saturating Q8.8 write per neuron into the output BRAM.
module fc_1 #(
  parameter int unsigned N_OUT  = 120,
  parameter int unsigned N_WORD = 16,
  parameter int unsigned LANES  = 25,
  parameter int unsigned FRAC   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fc_1_en,
  output logic                   fm_bram_enb,
  output logic [4:0]             fm_bram_addrb,
  input  logic [70*16-1:0]       fm_bram_doutb,
  output logic                   w_bram_en,
  output logic [10:0]            w_bram_addr,
  input  logic [LANES*16-1:0]    w_bram_dout,
  output logic [6:0]             b_bram_addr,
  input  logic [15:0]            b_bram_dout,
  output logic                   out_bram_wea,
  output logic [6:0]             out_bram_addra,
  output logic [15:0]            out_bram_dina,
  output logic                   fc_1_finish
);

  localparam int unsigned Stages  = 5;
  localparam logic [10:0] LastIdx = 11'(N_OUT * N_WORD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic        en_q;
  logic        start;
  logic        run;
  logic        last_write;
  logic [4:0]  word;
  logic [6:0]  neuron;

  assign start      = fc_1_en & ~en_q;
  assign run        = (state_q == StRun);
  assign word       = 5'(idx_q % 11'(N_WORD));
  assign neuron     = 7'(idx_q / 11'(N_WORD));
  assign last_write = out_bram_wea && (out_bram_addra == 7'(N_OUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      StDrain: begin
        if (last_write) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // en_q follows the pin even in reset so a level held through rst is not seen as an edge.
  always_ff @(posedge clk) begin
    en_q <= fc_1_en;
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx_q is held at zero outside RUN, so the addresses idle at zero.
  assign fm_bram_enb   = run;
  assign w_bram_en     = run;
  assign fm_bram_addrb = word;
  assign w_bram_addr   = idx_q;
  assign b_bram_addr   = neuron;
  assign fc_1_finish   = (state_q == StDone);

  // Tag pipeline: bit k describes the read issued k+1 cycles earlier.
  logic [Stages-1:0] vld_q;
  logic [Stages-1:0] lst_q;
  logic [3:0]        fst_q;
  logic [6:0]        nrn_q [Stages];

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[Stages-2:0], run};
    fst_q    <= {fst_q[2:0], word == 5'd0};
    lst_q    <= {lst_q[Stages-2:0], word == 5'(N_WORD - 1)};
    nrn_q[0] <= neuron;
    for (int i = 1; i < Stages; i++) nrn_q[i] <= nrn_q[i-1];
  end

  logic signed [31:0] prod_d [LANES];
  logic signed [31:0] prod_q [LANES];
  logic signed [36:0] sum_d, sum_q;
  logic signed [40:0] acc_q;
  logic signed [15:0] p_bias_q, s_bias_q, a_bias_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = 32'($signed(fm_bram_doutb[i*16 +: 16])) *
                  32'($signed(w_bram_dout[i*16 +: 16]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) sum_d = sum_d + 37'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    prod_q   <= prod_d;
    sum_q    <= sum_d;
    s_bias_q <= p_bias_q;
    if (vld_q[1] && fst_q[1]) p_bias_q <= $signed(b_bram_dout);
    if (vld_q[3]) begin
      acc_q <= fst_q[3] ? 41'(sum_q) : acc_q + 41'(sum_q);
      if (fst_q[3]) a_bias_q <= s_bias_q;
    end
  end

  logic signed [40:0] acc_sh;
  logic signed [41:0] r;
  logic [15:0]        res;

  assign acc_sh = acc_q >>> FRAC;
  assign r      = 42'(acc_sh) + 42'(a_bias_q);

  always_comb begin
    res = r[15:0];
    if (r < 42'sd0)          res = 16'h0000;
    else if (r > 42'sd32767) res = 16'h7FFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bram_wea   <= 1'b0;
      out_bram_addra <= '0;
      out_bram_dina  <= '0;
    end else if (vld_q[4] && lst_q[4]) begin
      out_bram_wea   <= 1'b1;
      out_bram_addra <= nrn_q[4];
      out_bram_dina  <= res;
    end else begin
      out_bram_wea <= 1'b0;
    end
  end

  // Lanes above LANES carry no data for this layer.
  logic unused_fm;
  assign unused_fm = ^fm_bram_doutb[70*16-1:LANES*16];

endmodule

// File: tb/tb_fc_1.sv
// Directed bench for fc_1: BRAM models with 2-cycle latency, a per-neuron arithmetic model,
// and a per-cycle compare of enables, addresses, writes and finish against the pass schedule.
module tb_fc_1;
  logic              clk = 1'b0;
  logic              rst;
  logic              fc_1_en;
  logic              fm_bram_enb;
  logic [4:0]        fm_bram_addrb;
  logic [70*16-1:0]  fm_bram_doutb;
  logic              w_bram_en;
  logic [10:0]       w_bram_addr;
  logic [25*16-1:0]  w_bram_dout;
  logic [6:0]        b_bram_addr;
  logic [15:0]       b_bram_dout;
  logic              out_bram_wea;
  logic [6:0]        out_bram_addra;
  logic [15:0]       out_bram_dina;
  logic              fc_1_finish;

  fc_1 dut (
    .clk           (clk),
    .rst           (rst),
    .fc_1_en       (fc_1_en),
    .fm_bram_enb   (fm_bram_enb),
    .fm_bram_addrb (fm_bram_addrb),
    .fm_bram_doutb (fm_bram_doutb),
    .w_bram_en     (w_bram_en),
    .w_bram_addr   (w_bram_addr),
    .w_bram_dout   (w_bram_dout),
    .b_bram_addr   (b_bram_addr),
    .b_bram_dout   (b_bram_dout),
    .out_bram_wea  (out_bram_wea),
    .out_bram_addra(out_bram_addra),
    .out_bram_dina (out_bram_dina),
    .fc_1_finish   (fc_1_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int S = -1000000;
  int stop_c = -1000000;
  bit fin_prev = 1'b0;
  bit chk_on = 1'b0;
  int fin_first = -1;
  logic [15:0] exp_res [120];
  logic [15:0] got [120];

  task automatic chk(input string nm, input longint g, input longint w);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, g, w);
    end
  endtask

  // Data patterns
  function automatic logic [15:0] fm_lane(int w, int l);
    if (mode == 0) return 16'h0000;
    if (l >= 25) return (mode == 1 || mode == 2) ? 16'hFFFF : 16'h5A5A;
    case (mode)
      1, 2:    return 16'h0100;
      3:       return 16'h7FFF;
      default: return 16'((((w * 7 + l * 3) % 11) - 5) * 64);
    endcase
  endfunction

  function automatic logic [15:0] wt(int idx, int l);
    case (mode)
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return 16'((((idx * 5 + l * 2) % 9) - 4) * 32);
    endcase
  endfunction

  function automatic logic [15:0] bias(int n);
    case (mode)
      0, 1:    return 16'h0000;
      2:       return 16'h0100;
      3:       return 16'h7FFF;
      default: return 16'(((n % 5) - 2) * 128);
    endcase
  endfunction

  function automatic logic [70*16-1:0] fm_word(int w);
    logic [70*16-1:0] v;
    for (int l = 0; l < 70; l++) v[l*16 +: 16] = fm_lane(w, l);
    return v;
  endfunction

  function automatic logic [25*16-1:0] w_word(int idx);
    logic [25*16-1:0] v;
    for (int l = 0; l < 25; l++) v[l*16 +: 16] = wt(idx, l);
    return v;
  endfunction

  // BRAMs: address registered, then output registered -> data visible two cycles later
  logic [4:0]  fm_a1;
  logic [10:0] w_a1;
  logic [6:0]  b_a1;
  always @(posedge clk) begin
    fm_a1         <= fm_bram_addrb;
    w_a1          <= w_bram_addr;
    b_a1          <= b_bram_addr;
    fm_bram_doutb <= fm_word(int'(fm_a1));
    w_bram_dout   <= w_word(int'(w_a1));
    b_bram_dout   <= bias(int'(b_a1));
  end

  task automatic compute_exp();
    for (int n = 0; n < 120; n++) begin
      longint acc = 0;
      longint rr;
      for (int w = 0; w < 16; w++)
        for (int l = 0; l < 25; l++)
          acc += longint'($signed(fm_lane(w, l))) * longint'($signed(wt(n * 16 + w, l)));
      rr = (acc >>> 8) + longint'($signed(bias(n)));
      if (rr < 0)          exp_res[n] = 16'h0000;
      else if (rr > 32767) exp_res[n] = 16'h7FFF;
      else                 exp_res[n] = 16'(rr);
      got[n] = 16'hDEAD;
    end
  endtask

  function automatic bit fin_exp(int c);
    return (c >= S + 1927 && c <= stop_c) || (c <= S && fin_prev);
  endfunction

  // Per-cycle compare against the pass schedule
  always @(negedge clk) begin
    if (chk_on) begin
      int c;
      int k;
      bit run_exp;
      bit w_exp;
      c = cyc;
      run_exp = (c >= S + 1 && c <= S + 1920 && c <= stop_c);
      chk("fm_enb", fm_bram_enb, run_exp);
      chk("w_en", w_bram_en, run_exp);
      if (run_exp) begin
        k = c - S - 1;
        chk("fm_addr", fm_bram_addrb, k % 16);
        chk("w_addr", w_bram_addr, k);
        chk("b_addr", b_bram_addr, k / 16);
      end
      k = c - S - 22;
      w_exp = (k >= 0 && k % 16 == 0 && k / 16 < 120 && c <= stop_c);
      chk("wea", out_bram_wea, w_exp);
      if (w_exp) begin
        chk("wr_addr", out_bram_addra, k / 16);
        chk("wr_data", out_bram_dina, exp_res[k / 16]);
      end
      if (out_bram_wea) got[out_bram_addra] = out_bram_dina;
      chk("finish", fc_1_finish, fin_exp(c));
      if (fc_1_finish && fin_first < 0 && c > S) fin_first = c;
    end
  end

  task automatic wait_to(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pass();
    @(posedge clk); #1;
    fc_1_en = 1'b0;
    @(posedge clk); #1;
    fin_prev  = fin_exp(cyc);
    S         = cyc;
    stop_c    = 32'h7FFF_FFFF;
    fin_first = -1;
    fc_1_en   = 1'b1;
  endtask

  task automatic run_full(input int m, input bit pin, input logic [15:0] lit, input bit toggle);
    mode = m;
    compute_exp();
    start_pass();
    if (toggle) begin
      wait_to(S + 300);
      fc_1_en = 1'b0;
      wait_to(S + 310);
      fc_1_en = 1'b1;
    end
    wait_to(S + 1935);
    chk("finish_at", fin_first - S, 1927);
    if (pin) begin
      chk("lit_n0", got[0], lit);
      chk("lit_n119", got[119], lit);
    end
  endtask

  initial begin
    rst = 1'b1;
    fc_1_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fm_enb", fm_bram_enb, 0);
    chk("rst_w_en", w_bram_en, 0);
    chk("rst_fm_addr", fm_bram_addrb, 0);
    chk("rst_w_addr", w_bram_addr, 0);
    chk("rst_b_addr", b_bram_addr, 0);
    chk("rst_wea", out_bram_wea, 0);
    chk("rst_wr_addr", out_bram_addra, 0);
    chk("rst_wr_data", out_bram_dina, 0);
    chk("rst_finish", fc_1_finish, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_full(0, 1'b1, 16'h0000, 1'b0);
    run_full(1, 1'b1, 16'h0190, 1'b1);
    run_full(2, 1'b1, 16'h0000, 1'b0);
    run_full(3, 1'b1, 16'h7FFF, 1'b0);

    // Mid-pass reset with the start level held high: nothing restarts
    mode = 4;
    compute_exp();
    start_pass();
    wait_to(S + 500);
    rst = 1'b1;
    stop_c = cyc;
    wait_to(S + 501);
    rst = 1'b0;
    wait_to(S + 620);
    chk("abort_no_finish", fin_first, -1);

    run_full(4, 1'b0, 16'h0000, 1'b0);
    run_full(4, 1'b0, 16'h0000, 1'b0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
